cp0_ctrl: RTL and testbench

- Parametrised coprocessor-0 for the 5-stage MIPS pipeline; sits beside the M stage.
- Holds SR(12), Cause(13), EPC(14) and PRId(15).
- Arbitrates hardware interrupts against synchronous exceptions reported by M, produces the flush/redirect request and EPC, and handles ERET.
- Generalises the previous CP0: configurable interrupt-line count and PRId, nested-exception protection, edge-latched interrupt pending, and an optional internal timer.

---
 rtl/cp0_pkg.sv | 41 ++++
 rtl/cp0_timer.sv | 40 ++++
 rtl/cp0_ctrl.sv | 155 +++++++++++++++
 tb/tb_cp0_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 block.
//   - CP0 register indices (SR, Cause, EPC, PRId, Count, Compare)
//   - exception codes written into Cause.ExcCode
//   - handler vector and SR/Cause bit positions
//   - epc_of(): EPC value for a faulting instruction
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

    // SR: IM[15:10], EXL[1], IE[0]; Cause: BD[31], IP[15:10], ExcCode[6:2]
    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD     = 31;

    // Index of the timer interrupt inside the 6-bit IP/IM field (IP[15]).
    localparam int TIMER_IP_IDX = 5;

    // A delay-slot fault reports the branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [29:0] word;
        word = bd ? (pc[31:2] - 30'd1) : pc[31:2];
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair with a sticky timer-interrupt flag.
//   clk, reset   : clock, synchronous active-high reset
//   wr_en        : accepted mtc0 this cycle
//   addr, wdata  : mtc0 register index and data
//   count, compare : current register values (for mfc0)
//   ti           : sticky timer interrupt, cleared by writing Compare
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            // Count wraps naturally at 2^32.
            if (wr_en && addr == CP0_COUNT) count <= wdata;
            else                            count <= count + 32'd1;

            // A Compare write wins over a same-cycle match.
            if (wr_en && addr == CP0_COMPARE) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor 0 beside the M stage. Holds SR, Cause, EPC, PRId,
// arbitrates interrupts against synchronous exceptions and handles ERET.
// Optional Count/Compare timer when CP0_TIMER_EN is defined.
//   clk, reset          : clock, synchronous active-high reset
//   hwint               : external interrupt lines
//   mtc0_we, cp0_addr, cp0_wdata : M-stage mtc0 write port
//   cp0_rdata           : mfc0 read data (combinational, pre-edge values)
//   pc_m, bd_m, exccode_m, eret_m : oldest M-stage instruction status
//   exc_req             : take exception/interrupt this cycle
//   epc_out, exl_out    : EPC for ERET redirect, SR.EXL
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID_VAL  = 32'h1937_7059,
    parameter int          LATCH_INT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 mtc0_we,
    input  logic [4:0]           cp0_addr,
    input  logic [31:0]          cp0_wdata,
    output logic [31:0]          cp0_rdata,
    input  logic [31:0]          pc_m,
    input  logic                 bd_m,
    input  logic [4:0]           exccode_m,
    input  logic                 eret_m,
    output logic                 exc_req,
    output logic [31:0]          epc_out,
    output logic                 exl_out
);

    localparam logic [5:0] HW_MASK = 6'((7'd1 << NUM_HWINT) - 7'd1);
`ifdef CP0_TIMER_EN
    localparam logic [5:0] IM_MASK = HW_MASK | (6'd1 << TIMER_IP_IDX);
`else
    localparam logic [5:0] IM_MASK = HW_MASK;
`endif

    logic [5:0]  im_q;
    logic        ie_q;
    logic        exl_q;
    logic        bd_q;
    logic [4:0]  exc_q;
    logic [31:0] epc_q;
    logic [5:0]  ip_q;
    logic [5:0]  hwint_q;
    logic [5:0]  hw6;
    logic [5:0]  ip_eff;
    logic [5:0]  ip_next;
    logic        int_req;
    logic        sync_req;
    logic        wr_ok;
    logic [4:0]  exc_code;

    // Zero-extend the interrupt lines into the 6-bit IP field.
    always_comb begin
        hw6 = '0;
        for (int i = 0; i < NUM_HWINT; i++) hw6[i] = hwint[i];
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    cp0_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .addr    (cp0_addr),
        .wdata   (cp0_wdata),
        .count   (count),
        .compare (compare),
        .ti      (ti)
    );

    // The timer owns IP[15], overriding hwint line 6.
    assign ip_eff = {ti, ip_q[4:0]};
`else
    assign ip_eff = ip_q;
`endif

    assign int_req  = (|(ip_eff & im_q)) & ie_q & ~exl_q;
    assign sync_req = (exccode_m != 5'd0) & ~exl_q;
    assign exc_req  = int_req | sync_req;
    assign exc_code = int_req ? EXC_INT : exccode_m;
    // A flushed instruction must not commit its mtc0 or eret.
    assign wr_ok    = mtc0_we & ~exc_req;
    assign epc_out  = epc_q;
    assign exl_out  = exl_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        ip_next = hw6;
        if (LATCH_INT != 0) begin
            ip_next = ip_q | (hw6 & ~hwint_q);
            if (wr_ok && cp0_addr == CP0_CAUSE)
                ip_next = ip_next & cp0_wdata[15:10];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q    <= '0;
            ie_q    <= 1'b0;
            exl_q   <= 1'b0;
            bd_q    <= 1'b0;
            exc_q   <= '0;
            epc_q   <= '0;
            ip_q    <= '0;
            hwint_q <= '0;
        end else begin
            ip_q    <= ip_next;
            hwint_q <= hw6;
            if (exc_req) begin
                exl_q <= 1'b1;
                exc_q <= exc_code;
                bd_q  <= bd_m;
                epc_q <= epc_of(pc_m, bd_m);
            end else begin
                if (mtc0_we) begin
                    case (cp0_addr)
                        CP0_SR: begin
                            im_q  <= cp0_wdata[15:10] & IM_MASK;
                            exl_q <= cp0_wdata[SR_EXL];
                            ie_q  <= cp0_wdata[SR_IE];
                        end
                        CP0_EPC: epc_q <= cp0_wdata;
                        default: ;
                    endcase
                end
                if (eret_m) exl_q <= 1'b0;
            end
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_SR:    cp0_rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
            CP0_CAUSE: cp0_rdata = {bd_q, 15'b0, ip_eff, 3'b0, exc_q, 2'b0};
            CP0_EPC:   cp0_rdata = epc_q;
            CP0_PRID:  cp0_rdata = PRID_VAL;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   cp0_rdata = count;
            CP0_COMPARE: cp0_rdata = compare;
`endif
            default:   cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed self-checking bench for cp0_ctrl (default parameters).
// Timer steps are compiled only when CP0_TIMER_EN is defined.
module tb_cp0_ctrl;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  hwint;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exccode_m;
    logic        eret_m;
    logic        exc_req;
    logic [31:0] epc_out;
    logic        exl_out;

    int n_cmp = 0;
    int n_bad = 0;

    cp0_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .hwint     (hwint),
        .mtc0_we   (mtc0_we),
        .cp0_addr  (cp0_addr),
        .cp0_wdata (cp0_wdata),
        .cp0_rdata (cp0_rdata),
        .pc_m      (pc_m),
        .bd_m      (bd_m),
        .exccode_m (exccode_m),
        .eret_m    (eret_m),
        .exc_req   (exc_req),
        .epc_out   (epc_out),
        .exl_out   (exl_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check(tag, cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
        step();
        mtc0_we = 1'b0; cp0_wdata = '0;
    endtask

    task automatic eret();
        eret_m = 1'b1;
        step();
        eret_m = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hwint = '0; mtc0_we = 1'b0; cp0_addr = '0; cp0_wdata = '0;
        pc_m = '0; bd_m = 1'b0; exccode_m = '0; eret_m = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        rd(CP0_PRID,  "prid_reset",  32'h1937_7059);
        rd(CP0_SR,    "sr_reset",    32'h0);
        rd(CP0_CAUSE, "cause_reset", 32'h0);
        rd(CP0_EPC,   "epc_reset",   32'h0);
        check("exc_req_reset", {31'b0, exc_req}, 32'h0);
        check("exl_reset",     {31'b0, exl_out}, 32'h0);

        // Enable all IM bits and IE
        mtc0(CP0_SR, 32'h0000_FC01);
        rd(CP0_SR, "sr_write", 32'h0000_FC01);

        // hwint[2]: IP registers it on the next edge, then exc_req fires
        hwint = 6'b000100; pc_m = 32'h1000;
        #1;
        check("int_not_yet", {31'b0, exc_req}, 32'h0);
        step();
        check("int_req", {31'b0, exc_req}, 32'h1);
        rd(CP0_CAUSE, "cause_ip12", 32'h0000_1000);
        hwint = '0;
        step();
        check("int_exl", {31'b0, exl_out}, 32'h1);
        rd(CP0_EPC,   "int_epc",   32'h0000_1000);
        rd(CP0_CAUSE, "int_cause", 32'h0);
        rd(CP0_SR,    "int_sr",    32'h0000_FC03);
        eret();
        check("eret1_exl", {31'b0, exl_out}, 32'h0);

        // Overflow in a delay slot
        exccode_m = EXC_OV; bd_m = 1'b1; pc_m = 32'h3008;
        #1;
        check("ov_req", {31'b0, exc_req}, 32'h1);
        step();
        exccode_m = '0; bd_m = 1'b0;
        rd(CP0_EPC,   "ov_epc",   32'h0000_3004);
        rd(CP0_CAUSE, "ov_cause", 32'h8000_0030);

        // Nested exception is masked by EXL
        exccode_m = EXC_ADEL; pc_m = 32'h3100;
        #1;
        check("nested_req", {31'b0, exc_req}, 32'h0);
        step();
        exccode_m = '0;
        rd(CP0_EPC,   "nested_epc",   32'h0000_3004);
        rd(CP0_CAUSE, "nested_cause", 32'h8000_0030);
        eret_m = 1'b1;
        #1;
        check("eret_epc_out", epc_out, 32'h0000_3004);
        step();
        eret_m = 1'b0;
        check("eret2_exl", {31'b0, exl_out}, 32'h0);

        // RI alongside an mtc0 EPC: the mtc0 is flushed
        exccode_m = EXC_RI; pc_m = 32'h3200;
        mtc0_we = 1'b1; cp0_addr = CP0_EPC; cp0_wdata = 32'hDEAD_0000;
        step();
        mtc0_we = 1'b0; exccode_m = '0;
        rd(CP0_EPC,   "ri_epc",   32'h0000_3200);
        rd(CP0_CAUSE, "ri_cause", 32'h0000_0028);
        eret();

        // Interrupt wins over AdEL
        hwint = 6'b000001;
        step();
        exccode_m = EXC_ADEL; pc_m = 32'h3300;
        #1;
        check("prio_req", {31'b0, exc_req}, 32'h1);
        step();
        exccode_m = '0;
        rd(CP0_CAUSE, "prio_cause", 32'h0000_0400);
        rd(CP0_EPC,   "prio_epc",   32'h0000_3300);

        // mtc0 EPC inside the handler; read is pre-edge
        mtc0_we = 1'b1; cp0_addr = CP0_EPC; cp0_wdata = 32'h1234_5678;
        #1;
        check("epc_no_bypass", cp0_rdata, 32'h0000_3300);
        step();
        mtc0_we = 1'b0;
        rd(CP0_EPC, "epc_mtc0", 32'h1234_5678);

        // Cause write ignored in level mode; PRId read-only; unknown address reads 0
        mtc0(CP0_CAUSE, 32'h0);
        rd(CP0_CAUSE, "cause_ro", 32'h0000_0400);
        mtc0(CP0_PRID, 32'h0);
        rd(CP0_PRID, "prid_ro", 32'h1937_7059);
        rd(5'd20, "addr20", 32'h0);
`ifndef CP0_TIMER_EN
        mtc0(CP0_COMPARE, 32'hFFFF_FFFF);
        rd(CP0_COMPARE, "compare_absent", 32'h0);
        rd(CP0_COUNT,   "count_absent",   32'h0);
`endif

        // Reset mid-handler
        reset = 1'b1;
        step();
        reset = 1'b0; hwint = '0;
        check("rst_exl", {31'b0, exl_out}, 32'h0);
        rd(CP0_CAUSE, "rst_cause", 32'h0);
        rd(CP0_SR,    "rst_sr",    32'h0);

`ifdef CP0_TIMER_EN
        begin
            bit hit;
            hit = 1'b0;
            mtc0(CP0_SR, 32'h0000_8001);
            mtc0(CP0_COMPARE, 32'd20);
            for (int i = 0; i < 100 && !hit; i++) begin
                if (exc_req) hit = 1'b1;
                else step();
            end
            check("timer_fired", {31'b0, hit}, 32'h1);
            rd(CP0_CAUSE, "timer_ip15", 32'h0000_8000);
            step();
            mtc0(CP0_COMPARE, 32'd1000);
            rd(CP0_CAUSE, "timer_clear", 32'h0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
